// File: rtl/rx_fifo_buffer.sv
// Receive-side FIFO for the UART receiver: captures packets on load_buffer and
// presents the oldest unread byte first-word-fall-through, with overrun status.
module rx_fifo_buffer #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   load_buffer,
    input  logic [DATA_BITS-1:0]   packet_data,
    input  logic                   data_read,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic                   data_ready,
    output logic                   overrun_error,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overrun_q, overrun_d;

    logic is_full;
    logic is_empty;
    logic do_push;
    logic do_pop;
    logic do_drop;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        is_full   = 1'b0;
        is_empty  = 1'b0;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        do_drop   = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        is_full  = (count_q == FULL_CNT);
        is_empty = (count_q == '0);

        // A full FIFO still accepts a packet when the host frees a slot in the same cycle.
        do_pop  = data_read && !is_empty;
        do_push = load_buffer && (!is_full || data_read);
        do_drop = load_buffer && is_full && !data_read;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (do_drop) begin
            overrun_d = 1'b1;
        end else if (data_read) begin
            overrun_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; its contents are
    // unobservable because rx_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= packet_data;
        end
    end

    assign rx_data       = is_empty ? '0 : mem_q[rd_ptr_q];
    assign data_ready    = !is_empty;
    assign overrun_error = overrun_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_rx_fifo_buffer.sv
// Self-checking bench for rx_fifo_buffer: directed test-plan scenarios plus
// random push/pop traffic compared against a queue-based reference model.
module tb_rx_fifo_buffer;

    localparam int DATA_BITS = 8;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 n_rst;
    logic                 load_buffer;
    logic [DATA_BITS-1:0] packet_data;
    logic                 data_read;
    logic [DATA_BITS-1:0] rx_data;
    logic                 data_ready;
    logic                 overrun_error;
    logic [CNT_W-1:0]     fifo_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: an ordered list of held bytes and a sticky overrun bit.
    logic [DATA_BITS-1:0] model_q[$];
    bit                   model_ovr;

    rx_fifo_buffer #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .load_buffer   (load_buffer),
        .packet_data   (packet_data),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step(input bit ld, input logic [DATA_BITS-1:0] d, input bit rd);
        int n = model_q.size();
        if (rd && n > 0) void'(model_q.pop_front());
        if (ld && (n < DEPTH || rd)) model_q.push_back(d);
        if (ld && n == DEPTH && !rd) model_ovr = 1'b1;
        else if (rd)                 model_ovr = 1'b0;
    endfunction

    task automatic check_all(input string tag);
        logic [DATA_BITS-1:0] head;
        head = (model_q.size() > 0) ? model_q[0] : '0;
        check({tag, ".rx_data"}, 32'(rx_data), 32'(head));
        check({tag, ".ready"},   32'(data_ready), 32'(model_q.size() != 0));
        check({tag, ".count"},   32'(fifo_count), 32'(model_q.size()));
        check({tag, ".ovr"},     32'(overrun_error), 32'(model_ovr));
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input string tag, input bit ld, input logic [DATA_BITS-1:0] d, input bit rd);
        @(negedge clk);
        load_buffer = ld;
        packet_data = d;
        data_read   = rd;
        @(posedge clk);
        model_step(ld, d, rd);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 8'hEE, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        load_buffer = 1'b0;
        data_read   = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        model_q.delete();
        model_ovr = 1'b0;
        check("rst.rx_data", 32'(rx_data), 32'h0);
        check("rst.ready",   32'(data_ready), 32'h0);
        check("rst.count",   32'(fifo_count), 32'h0);
        check("rst.ovr",     32'(overrun_error), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        load_buffer = 1'b0;
        packet_data = '0;
        data_read   = 1'b0;
        n_rst       = 1'b1;
        model_ovr   = 1'b0;
        #3 n_rst = 1'b0;
        #1;
        check("por.count", 32'(fifo_count), 32'h0);
        check("por.ready", 32'(data_ready), 32'h0);
        check("por.rx",    32'(rx_data), 32'h0);
        @(negedge clk);
        n_rst = 1'b1;
        idle("idle0");

        // Single push then pop.
        cyc("push_a5", 1'b1, 8'hA5, 1'b0);
        check("a5.head", 32'(rx_data), 32'hA5);
        cyc("pop_a5", 1'b0, 8'h00, 1'b1);
        check("a5.empty_rx", 32'(rx_data), 32'h0);

        // Fill, then drain in order.
        cyc("fill1", 1'b1, 8'h11, 1'b0);
        cyc("fill2", 1'b1, 8'h22, 1'b0);
        cyc("fill3", 1'b1, 8'h33, 1'b0);
        cyc("fill4", 1'b1, 8'h44, 1'b0);
        check("fill.count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, 8'h00, 1'b1);

        // Overrun: drop 0x55, then clear it with a pop.
        cyc("refill1", 1'b1, 8'h11, 1'b0);
        cyc("refill2", 1'b1, 8'h22, 1'b0);
        cyc("refill3", 1'b1, 8'h33, 1'b0);
        cyc("refill4", 1'b1, 8'h44, 1'b0);
        cyc("drop55", 1'b1, 8'h55, 1'b0);
        check("drop.ovr",  32'(overrun_error), 32'h1);
        check("drop.head", 32'(rx_data), 32'h11);
        cyc("clr_pop", 1'b0, 8'h00, 1'b1);
        check("clr.ovr",  32'(overrun_error), 32'h0);
        check("clr.head", 32'(rx_data), 32'h22);

        // Full with simultaneous push 0x66 and pop; 0x66 drains last.
        cyc("refill5", 1'b1, 8'h55, 1'b0);
        cyc("full_both", 1'b1, 8'h66, 1'b1);
        check("both.count", 32'(fifo_count), 32'd4);
        check("both.head",  32'(rx_data), 32'h33);
        for (int i = 0; i < 3; i++) cyc("drain66", 1'b0, 8'h00, 1'b1);
        check("last66", 32'(rx_data), 32'h66);
        cyc("drain_last", 1'b0, 8'h00, 1'b1);

        // Empty with simultaneous push and read; then a read on empty.
        cyc("empty_both", 1'b1, 8'h77, 1'b1);
        check("eb.rx", 32'(rx_data), 32'h77);
        cyc("pop77", 1'b0, 8'h00, 1'b1);
        cyc("read_empty", 1'b0, 8'h00, 1'b1);

        // Wrap pointers twice with count held at 2, then reset mid-stream.
        cyc("wrap_a", 1'b1, 8'h01, 1'b0);
        cyc("wrap_b", 1'b1, 8'h02, 1'b0);
        for (int i = 0; i < 6; i++) cyc("wrap", 1'b1, 8'(8'h10 + i), 1'b1);
        check("wrap.count", 32'(fifo_count), 32'd2);
        do_reset();
        cyc("post_rst", 1'b1, 8'h99, 1'b0);
        check("post.rx", 32'(rx_data), 32'h99);
        cyc("post_pop", 1'b0, 8'h00, 1'b1);

        // Random traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            bit ld, rd;
            ld = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 499) == 0) do_reset();
            cyc("rand", ld, 8'($urandom), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
